// File: rtl/tone_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// tone_packetizer_pkg
//   Shared definitions for the tone packetizer: stream widths, header and
//   payload field layout, default header signature, read FSM state encoding,
//   the buffered payload entry and a header builder.
// -----------------------------------------------------------------------------
package tone_packetizer_pkg;

  // Stream widths
  localparam int unsigned S_DATA_W = 80;   // I/Q sample word
  localparam int unsigned S_USER_W = 21;   // {index[6:0], k[13:0]}
  localparam int unsigned M_DATA_W = 128;  // DMA-side word

  // Payload word layout: [79:0] data, [86:80] index, [100:87] k, rest zero
  localparam int unsigned PL_DATA_LSB  = 0;
  localparam int unsigned PL_DATA_W    = 80;
  localparam int unsigned PL_INDEX_LSB = 80;
  localparam int unsigned PL_INDEX_W   = 7;
  localparam int unsigned PL_K_LSB     = 87;
  localparam int unsigned PL_K_W       = 14;
  localparam int unsigned ENTRY_W      = PL_DATA_W + PL_INDEX_W + PL_K_W;  // 101
  localparam int unsigned PL_PAD_W     = M_DATA_W - ENTRY_W;               // 27

  // Header word layout
  localparam int unsigned HDR_MAGIC_LSB = 112;
  localparam int unsigned HDR_MAGIC_W   = 16;
  localparam int unsigned HDR_SEQ_LSB   = 80;
  localparam int unsigned HDR_SEQ_W     = 32;
  localparam int unsigned HDR_DROP_LSB  = 64;
  localparam int unsigned HDR_DROP_W    = 16;
  localparam int unsigned HDR_TS_LSB    = 32;
  localparam int unsigned HDR_TS_W      = 32;
  localparam int unsigned HDR_TRUNC_BIT = 16;
  localparam int unsigned HDR_COUNT_LSB = 0;
  localparam int unsigned HDR_COUNT_W   = 16;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hF5E1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_HEADER,
    RD_PAYLOAD
  } rd_state_e;

  // One buffered beat; packing order matches the payload word bit positions.
  typedef struct packed {
    logic [PL_K_W-1:0]     k;
    logic [PL_INDEX_W-1:0] index;
    logic [PL_DATA_W-1:0]  data;
  } entry_t;

  function automatic logic [M_DATA_W-1:0] build_header(
    input logic [HDR_MAGIC_W-1:0] magic,
    input logic [HDR_SEQ_W-1:0]   seq,
    input logic [HDR_DROP_W-1:0]  drops,
    input logic [HDR_TS_W-1:0]    ts,
    input logic                   trunc,
    input logic [HDR_COUNT_W-1:0] count
  );
    logic [M_DATA_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
    h[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
    h[HDR_DROP_LSB  +: HDR_DROP_W]  = drops;
    h[HDR_TS_LSB    +: HDR_TS_W]    = ts;
    h[HDR_TRUNC_BIT]                = trunc;
    h[HDR_COUNT_LSB +: HDR_COUNT_W] = count;
    return h;
  endfunction

endpackage

// File: rtl/tone_packetizer_if.sv
// -----------------------------------------------------------------------------
// tone_packetizer_if
//   AXI-stream style bundle used on both sides of the packetizer.
//   Signals: tdata[DATA_W], tuser[USER_W], tvalid, tready, tlast.
//   master: drives tdata/tuser/tvalid/tlast, receives tready.
//   slave : receives tdata/tuser/tvalid/tlast, drives tready.
// -----------------------------------------------------------------------------
interface tone_packetizer_if
  import tone_packetizer_pkg::*;
#(
  parameter int unsigned DATA_W = S_DATA_W,
  parameter int unsigned USER_W = S_USER_W
);

  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);

endinterface

// File: rtl/tp_frame_bank.sv
// -----------------------------------------------------------------------------
// tp_frame_bank
//   Simple dual-port RAM holding both ping-pong banks (2*DEPTH x WIDTH).
//   The address MSB selects the bank. Reads are registered (1-cycle latency).
//   Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
// -----------------------------------------------------------------------------
module tp_frame_bank #(
  parameter  int unsigned DEPTH = 128,
  parameter  int unsigned WIDTH = 101,
  localparam int unsigned AW    = $clog2(2 * DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2 * DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; bank occupancy is
  // tracked by reset-able pointers elsewhere, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tone_packetizer.sv
// -----------------------------------------------------------------------------
// tone_packetizer
//   Captures frames of selected-tone samples into a ping-pong buffer and emits
//   each completed frame as one header beat plus payload beats on a 128-bit
//   stream. The input is never back-pressured; frames that finish while the
//   reader still owns the other bank are dropped and counted.
//
// Ports:
//   dev_clk, dev_aresetn  clock, asynchronous active-low reset
//   s_axis (slave)        80-bit sample, tuser = {index[6:0], k[13:0]}
//   m_axis (master)       128-bit header / payload words toward the DMA
//   frame_count[31:0]     frames fully emitted (wraps); also the header seq
//   drop_count[15:0]      frames dropped (saturating)
//
// Build option: define TONE_PACKETIZER_TIMESTAMP_EN to put a free-running
// dev_clk cycle count, latched on the tlast beat, into header [63:32].
// -----------------------------------------------------------------------------
module tone_packetizer
  import tone_packetizer_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter logic [15:0] MAGIC = DEFAULT_MAGIC
) (
  input  logic              dev_clk,
  input  logic              dev_aresetn,
  tone_packetizer_if.slave  s_axis,
  tone_packetizer_if.master m_axis,
  output logic [31:0]       frame_count,
  output logic [15:0]       drop_count
);

  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  // ---------------------------------------------------------------- write side
  logic             s_ready_q;
  logic             wr_bank_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic             trunc_q;

  logic             beat, last_beat, room, wr_en;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_trunc;
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [PTR_W:0]   rd_addr;
  logic [31:0]      ts_now;

  // ---------------------------------------------------------------- read side
  rd_state_e        state_q, state_d;
  logic [PTR_W-1:0] rd_idx_q, rd_idx_d;
  logic             rd_bank_q;
  logic [CNT_W-1:0] rd_count_q;
  logic             rd_trunc_q;
  logic [15:0]      rd_drop_q;
  logic [31:0]      rd_ts_q;
  logic [31:0]      frame_count_q;
  logic [15:0]      drop_count_q;

  logic             m_hs, last_pl, release_bank, rd_free, handoff, drop;
  logic             m_valid, m_last;
  logic [M_DATA_W-1:0] m_data;

  assign beat      = s_axis.tvalid && s_ready_q;
  assign last_beat = beat && s_axis.tlast;
  assign room      = (wr_cnt_q != FULL);
  assign wr_en     = beat && room;

  // Length and truncation of the frame whose tlast is accepted this cycle.
  assign frame_cnt   = room ? (wr_cnt_q + CNT_W'(1)) : wr_cnt_q;
  assign frame_trunc = trunc_q || !room;

  assign wr_entry = '{k:     s_axis.tuser[PL_K_W-1:0],
                      index: s_axis.tuser[S_USER_W-1:PL_K_W],
                      data:  s_axis.tdata};

  // The reader's bank counts as free when it is idle or is releasing the bank
  // on this very edge, so a coincident tlast is handed over, not dropped.
  assign m_hs         = m_valid && m_axis.tready;
  assign last_pl      = (state_q == RD_PAYLOAD) && ({1'b0, rd_idx_q} == rd_count_q - CNT_W'(1));
  assign release_bank = m_hs && last_pl;
  assign rd_free      = (state_q == RD_IDLE) || release_bank;
  assign handoff      = last_beat && rd_free;
  assign drop         = last_beat && !rd_free;

`ifdef TONE_PACKETIZER_TIMESTAMP_EN
  logic [31:0] cyc_q;

  always_ff @(posedge dev_clk or negedge dev_aresetn) begin
    if (!dev_aresetn) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign ts_now = cyc_q;
`else
  assign ts_now = '0;
`endif

  tp_frame_bank #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_bank (
    .clk   (dev_clk),
    .we    (wr_en),
    .waddr ({wr_bank_q, wr_cnt_q[PTR_W-1:0]}),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of all the others.
  always_ff @(posedge dev_clk or negedge dev_aresetn) begin
    if (!dev_aresetn) begin
      s_ready_q     <= 1'b0;
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      trunc_q       <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_count_q    <= '0;
      rd_trunc_q    <= 1'b0;
      rd_drop_q     <= '0;
      rd_ts_q       <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      s_ready_q <= 1'b1;

      if (last_beat) begin
        // Both hand-off and drop restart the write pointer; only a hand-off
        // flips banks, a drop reuses the current one.
        wr_cnt_q <= '0;
        trunc_q  <= 1'b0;
      end else if (beat) begin
        if (room) begin
          wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end else begin
          trunc_q <= 1'b1;
        end
      end

      if (handoff) begin
        wr_bank_q  <= !wr_bank_q;
        rd_bank_q  <= wr_bank_q;
        rd_count_q <= frame_cnt;
        rd_trunc_q <= frame_trunc;
        rd_drop_q  <= drop_count_q;
        rd_ts_q    <= ts_now;
      end

      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end

      if (release_bank) begin
        frame_count_q <= frame_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge dev_clk or negedge dev_aresetn) begin
    if (!dev_aresetn) begin
      state_q  <= RD_IDLE;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // The RAM address is the beat currently presented, or the next one on a
  // payload handshake, so registered read data is always ready one cycle
  // ahead; the first payload beat is fetched while the header is presented.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    rd_addr  = {rd_bank_q, rd_idx_q};
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = '0;

    unique case (state_q)
      RD_IDLE: begin
        if (handoff) begin
          state_d  = RD_HEADER;
          rd_idx_d = '0;
        end
      end

      RD_HEADER: begin
        m_valid = 1'b1;
        m_data  = build_header(MAGIC, frame_count_q, rd_drop_q, rd_ts_q, rd_trunc_q,
                               16'(rd_count_q));
        if (m_hs) begin
          state_d = RD_PAYLOAD;
        end
      end

      RD_PAYLOAD: begin
        m_valid = 1'b1;
        m_last  = last_pl;
        m_data  = {{PL_PAD_W{1'b0}}, rd_entry};
        if (m_hs) begin
          if (last_pl) begin
            // A frame handed over on the releasing edge goes straight to its
            // header instead of idling for a cycle.
            state_d  = handoff ? RD_HEADER : RD_IDLE;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + PTR_W'(1);
            rd_addr  = {rd_bank_q, rd_idx_q + PTR_W'(1)};
          end
        end
      end

      default: begin
        state_d  = RD_IDLE;
        rd_idx_d = '0;
      end
    endcase
  end

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdata  = m_data;
  assign m_axis.tuser  = '0;
  assign frame_count   = frame_count_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_tone_packetizer.sv
// -----------------------------------------------------------------------------
// tb_tone_packetizer
//   Directed bench for tone_packetizer (DEPTH=128): a table of single-frame
//   vectors plus hand-written sequences for drop, coincident release/tlast and
//   reset mid-payload. Output beats are collected by a monitor and compared
//   against values the bench derives from its own stimulus.
// -----------------------------------------------------------------------------
module tb_tone_packetizer;

  logic        dev_clk = 1'b0;
  logic        dev_aresetn = 1'b0;
  logic [31:0] frame_count;
  logic [15:0] drop_count;

  always #5 dev_clk = ~dev_clk;

  tone_packetizer_if #(.DATA_W(80),  .USER_W(21)) s_if ();
  tone_packetizer_if #(.DATA_W(128), .USER_W(1))  m_if ();

  tone_packetizer #(
    .DEPTH (128),
    .MAGIC (16'hF5E1)
  ) dut (
    .dev_clk     (dev_clk),
    .dev_aresetn (dev_aresetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge dev_clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           cyc;
  } beat_t;

  beat_t got[$];

  typedef struct {
    int         n;
    int         idx0;
    logic [13:0] k;
    bit         toggle;
    bit         trunc;
    int         count;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: record handshakes and verify the held word while stalled.
  logic         stall_q = 1'b0;
  logic [127:0] hold_data;
  logic         hold_last;

  always @(negedge dev_clk) begin
    if (!dev_aresetn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_tvalid", m_if.tvalid, 1'b1);
        check("hold_tdata", m_if.tdata, hold_data);
        check("hold_tlast", m_if.tlast, hold_last);
      end
      if (m_if.tvalid && m_if.tready) got.push_back('{data: m_if.tdata, last: m_if.tlast, cyc: cyc});
      stall_q   = m_if.tvalid && !m_if.tready;
      hold_data = m_if.tdata;
      hold_last = m_if.tlast;
    end
  end

  function automatic logic [79:0] mk_data(input int tag, input int i);
    return {16'(tag) ^ 16'hC0DE, 32'(i), 32'h5A000000 + 32'(tag << 12) + 32'(i)};
  endfunction

  function automatic logic [127:0] mk_payload(input int tag, input int i, input int idx0,
                                              input logic [13:0] k);
    logic [6:0] idx;
    idx = 7'(idx0 + i);
    return {27'd0, k, idx, mk_data(tag, i)};
  endfunction

  task automatic send_frame(input int tag, input int n, input int idx0, input logic [13:0] k,
                            output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk_data(tag, i);
      s_if.tuser  = {7'(idx0 + i), k};
      s_if.tlast  = (i == n - 1);
      if (i == n - 1) last_cyc = cyc;
      @(posedge dev_clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input bit toggle, output bit ok);
    int guard;
    guard = 0;
    while (got.size() < n && guard < 2000) begin
      @(posedge dev_clk); #1;
      if (toggle) m_if.tready = ~m_if.tready;
      guard++;
    end
    ok = (got.size() >= n);
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: waiting for %0d beats, have %0d", n, got.size());
    end
  endtask

  task automatic expect_packet(input int seq, input int drops, input bit trunc, input int count,
                               input int tag, input int idx0, input logic [13:0] k,
                               input bit toggle, input bit timing, input int tlast_cyc,
                               output int last_pl_cyc);
    beat_t h, b;
    bit    ok;
    last_pl_cyc = -1;
    wait_beats(count + 1, toggle, ok);
    m_if.tready = 1'b1;
    if (!ok) begin
      got.delete();
      return;
    end
    h = got.pop_front();
    check("hdr_magic", h.data[127:112], 16'hF5E1);
    check("hdr_seq", h.data[111:80], 32'(seq));
    check("hdr_drop", h.data[79:64], 16'(drops));
`ifdef TONE_PACKETIZER_TIMESTAMP_EN
    check("hdr_ts_nonzero", h.data[63:32] != 32'd0, 1'b1);
`else
    check("hdr_ts", h.data[63:32], 32'd0);
`endif
    check("hdr_zero", h.data[31:17], 15'd0);
    check("hdr_trunc", h.data[16], trunc);
    check("hdr_count", h.data[15:0], 16'(count));
    check("hdr_tlast", h.last, 1'b0);
    if (timing) check("hdr_latency", h.cyc, tlast_cyc + 1);
    b = h;
    for (int i = 0; i < count; i++) begin
      b = got.pop_front();
      check("payload", b.data, mk_payload(tag, i, idx0, k));
      check("payload_tlast", b.last, (i == count - 1));
    end
    last_pl_cyc = b.cyc;
    if (timing) check("packet_span", b.cyc - h.cyc, count);
    check("frame_count", frame_count, 32'(seq + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq, drops, tag, lc, lc2, lp, dummy, x_drop;

    vecs[0] = '{n: 3,   idx0: 0,    k: 14'd100,    toggle: 1'b0, trunc: 1'b0, count: 3};
    vecs[1] = '{n: 1,   idx0: 5,    k: 14'h3FFF,   toggle: 1'b0, trunc: 1'b0, count: 1};
    vecs[2] = '{n: 128, idx0: 0,    k: 14'd7,      toggle: 1'b0, trunc: 1'b0, count: 128};
    vecs[3] = '{n: 130, idx0: 0,    k: 14'd9,      toggle: 1'b0, trunc: 1'b1, count: 128};
    vecs[4] = '{n: 6,   idx0: 'h7C, k: 14'h2AAA,   toggle: 1'b1, trunc: 1'b0, count: 6};

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    dev_aresetn = 1'b0;

    // Reset state
    repeat (3) @(posedge dev_clk);
    #1;
    check("rst_s_tready", s_if.tready, 1'b0);
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_m_tlast", m_if.tlast, 1'b0);
    check("rst_m_tdata", m_if.tdata, 128'd0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_drop_count", drop_count, 16'd0);
    @(negedge dev_clk) dev_aresetn = 1'b1;
    @(posedge dev_clk); #1;
    check("run_s_tready", s_if.tready, 1'b1);
    check("idle_m_tvalid", m_if.tvalid, 1'b0);

    seq   = 0;
    drops = 0;
    tag   = 1;

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      m_if.tready = 1'b1;
      send_frame(tag, vecs[v].n, vecs[v].idx0, vecs[v].k, lc);
      expect_packet(seq, drops, vecs[v].trunc, vecs[v].count, tag, vecs[v].idx0, vecs[v].k,
                    vecs[v].toggle, !vecs[v].toggle, lc, dummy);
      seq++;
      tag++;
    end

    // Second frame completes while the first is stalled in HEADER -> dropped
    m_if.tready = 1'b0;
    send_frame(tag, 4, 10, 14'd200, lc);
    send_frame(tag + 1, 4, 20, 14'd201, lc2);
    x_drop = drops;
    drops++;
    check("drop_count_after_drop", drop_count, 16'(drops));
    repeat (3) @(posedge dev_clk);
    #1;
    check("stalled_header_valid", m_if.tvalid, 1'b1);
    m_if.tready = 1'b1;
    expect_packet(seq, x_drop, 1'b0, 4, tag, 10, 14'd200, 1'b0, 1'b0, lc, dummy);
    seq++;
    tag += 2;
    send_frame(tag, 4, 30, 14'd202, lc);
    expect_packet(seq, drops, 1'b0, 4, tag, 30, 14'd202, 1'b0, 1'b1, lc, dummy);
    seq++;
    tag++;

    // Second frame's tlast coincides with the first frame's final handshake
    m_if.tready = 1'b1;
    send_frame(tag, 2, 40, 14'd300, lc);
    @(posedge dev_clk); #1;
    send_frame(tag + 1, 2, 50, 14'd301, lc2);
    expect_packet(seq, drops, 1'b0, 2, tag, 40, 14'd300, 1'b0, 1'b1, lc, lp);
    check("coincident_cycle", lp, lc2);
    seq++;
    expect_packet(seq, drops, 1'b0, 2, tag + 1, 50, 14'd301, 1'b0, 1'b1, lc2, dummy);
    check("no_drop_on_coincide", drop_count, 16'(drops));
    seq++;
    tag += 2;

    // Reset in the middle of a payload
    m_if.tready = 1'b1;
    send_frame(tag, 10, 0, 14'd5, lc);
    repeat (4) @(posedge dev_clk);
    #1;
    check("mid_payload_valid", m_if.tvalid, 1'b1);
    dev_aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_if.tvalid, 1'b0);
    check("mid_rst_s_tready", s_if.tready, 1'b0);
    check("mid_rst_frame_count", frame_count, 32'd0);
    check("mid_rst_drop_count", drop_count, 16'd0);
    repeat (2) @(posedge dev_clk);
    @(negedge dev_clk) dev_aresetn = 1'b1;
    @(posedge dev_clk); #1;
    got.delete();
    seq   = 0;
    drops = 0;
    tag++;
    send_frame(tag, 2, 3, 14'd55, lc);
    expect_packet(seq, drops, 1'b0, 2, tag, 3, 14'd55, 1'b0, 1'b1, lc, dummy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
